// File: rtl/eflags_ctrl.sv
// Architectural EFLAGS owner: merges masked flag writebacks, counts in-flight
// flag writers, and tells flag consumers when the flags are resolved.
module eflags_ctrl #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             dec_reserve,
   input  logic             dec_consume,
   input  logic             wb_valid,
   input  logic [6:0]       wb_mask,
   input  logic [31:0]      wb_flags,
   input  logic             flush,
   output logic [31:0]      flags,
   output logic [31:0]      flags_fwd,
   output logic             flags_ready,
   output logic             full,
   output logic [CNT_W-1:0] pending_cnt,
   output logic             wb_err
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   // EFLAGS bit position of each wb_mask bit, {OF,DF,SF,ZF,AF,PF,CF} order
   localparam int FLAG_POS [7] = '{0, 2, 4, 6, 7, 10, 11};

   logic [31:0]      flags_reg;
   logic [31:0]      flags_next;
   logic [31:0]      wr_en;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             err_reg;
   logic             err_set;
   logic             cnt_zero;
   logic             unused_consume;

   // dec_consume only qualifies the stall outside this block
   assign unused_consume = dec_consume;

   always_comb begin
      wr_en = '0;
      for (int i = 0; i < 7; i++) begin
         wr_en[FLAG_POS[i]] = wb_valid & wb_mask[i];
      end
   end

   // wr_en only ever covers flag bits, so reserved bits stay 0 from reset
   assign flags_next = (flags_reg & ~wr_en) | (wb_flags & wr_en);

   assign cnt_zero = (cnt_reg == '0);
   assign full     = (cnt_reg == DEPTH_C);

   always_comb begin
      cnt_next = cnt_reg;
      if (flush) begin
         cnt_next = '0;
      end else if (dec_reserve && !wb_valid && !full) begin
         cnt_next = cnt_reg + 1'b1;
      end else if (wb_valid && !dec_reserve && !cnt_zero) begin
         cnt_next = cnt_reg - 1'b1;
      end
   end

   // A reserve dropped by flush is not an overflow
   assign err_set = (wb_valid && cnt_zero) ||
                    (dec_reserve && full && !wb_valid && !flush);

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         flags_reg <= '0;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         flags_reg <= flags_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_reg | err_set;
      end
   end

   assign flags       = flags_reg;
   assign flags_fwd   = flags_next;
   assign pending_cnt = cnt_reg;
   assign wb_err      = err_reg;
   // A writer issued alongside a consumer is younger, so dec_reserve is ignored here
   assign flags_ready = cnt_zero || ((cnt_reg == CNT_W'(1)) && wb_valid);

endmodule

// File: tb/tb_eflags_ctrl.sv
// Directed bench for eflags_ctrl: hand-computed vectors checked with immediate assertions.
module tb_eflags_ctrl;

   logic        CLK = 1'b0;
   logic        CLR = 1'b0;
   logic        dec_reserve = 1'b0;
   logic        dec_consume = 1'b0;
   logic        wb_valid = 1'b0;
   logic [6:0]  wb_mask = '0;
   logic [31:0] wb_flags = '0;
   logic        flush = 1'b0;
   logic [31:0] flags;
   logic [31:0] flags_fwd;
   logic        flags_ready;
   logic        full;
   logic [2:0]  pending_cnt;
   logic        wb_err;

   int total = 0;
   int bad = 0;

   eflags_ctrl #(.DEPTH(4), .CNT_W(3)) dut (
      .CLK(CLK), .CLR(CLR), .dec_reserve(dec_reserve), .dec_consume(dec_consume),
      .wb_valid(wb_valid), .wb_mask(wb_mask), .wb_flags(wb_flags), .flush(flush),
      .flags(flags), .flags_fwd(flags_fwd), .flags_ready(flags_ready), .full(full),
      .pending_cnt(pending_cnt), .wb_err(wb_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      dec_reserve = 1'b0; dec_consume = 1'b0; wb_valid = 1'b0;
      wb_mask = '0; wb_flags = '0; flush = 1'b0;
   endtask

   task automatic pulse_reset();
      #3 CLR = 1'b0;
      #1 CLR = 1'b1;
   endtask

   initial begin
      // reset release between edges
      #12 CLR = 1'b1;
      cyc();
      chk("rst_flags", flags, 32'h0);
      chk("rst_cnt", 32'(pending_cnt), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_ready", 32'(flags_ready), 32'd1);
      chk("rst_err", 32'(wb_err), 32'd0);
      $display("txn reset: flags=%h cnt=%0d", flags, pending_cnt);

      // full-mask writeback of all ones
      wb_valid = 1'b1; wb_mask = 7'h7F; wb_flags = 32'hFFFF_FFFF;
      #2 chk("all_fwd", flags_fwd, 32'h0000_0CD5);
      chk("all_flags_old", flags, 32'h0);
      cyc(); idle();
      #2 chk("all_flags", flags, 32'h0000_0CD5);
      chk("idle_fwd", flags_fwd, 32'h0000_0CD5);
      $display("txn wb all: flags=%h", flags);

      // CF-only clear
      wb_valid = 1'b1; wb_mask = 7'b0000001; wb_flags = 32'h0;
      #2 chk("cf_fwd", flags_fwd, 32'h0000_0CD4);
      cyc(); idle();
      #2 chk("cf_flags", flags, 32'h0000_0CD4);
      chk("cf_err", 32'(wb_err), 32'd1);
      $display("txn wb cf: flags=%h err=%0d", flags, wb_err);

      pulse_reset();
      chk("rst2_flags", flags, 32'h0);
      chk("rst2_err", 32'(wb_err), 32'd0);
      cyc();

      // fill to DEPTH
      for (int i = 0; i < 4; i++) begin
         dec_reserve = 1'b1;
         cyc();
      end
      idle();
      #2 chk("fill_cnt", 32'(pending_cnt), 32'd4);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_ready", 32'(flags_ready), 32'd0);
      chk("fill_err", 32'(wb_err), 32'd0);
      $display("txn fill: cnt=%0d full=%0d", pending_cnt, full);

      dec_reserve = 1'b1;
      cyc(); idle();
      #2 chk("ovf_cnt", 32'(pending_cnt), 32'd4);
      chk("ovf_err", 32'(wb_err), 32'd1);

      dec_reserve = 1'b1; wb_valid = 1'b1; wb_mask = 7'b0;
      cyc(); idle();
      #2 chk("full_rsv_wb_cnt", 32'(pending_cnt), 32'd4);
      $display("txn overflow: cnt=%0d err=%0d", pending_cnt, wb_err);

      // drain; readiness only on the last writeback
      for (int i = 0; i < 4; i++) begin
         wb_valid = 1'b1; wb_mask = 7'b0000001; wb_flags = 32'h1;
         #2;
         if (i < 3) chk("drain_ready_lo", 32'(flags_ready), 32'd0);
         else begin
            chk("drain_ready_hi", 32'(flags_ready), 32'd1);
            chk("drain_fwd", flags_fwd, 32'h1);
         end
         cyc(); idle();
      end
      #2 chk("drain_cnt", 32'(pending_cnt), 32'd0);
      chk("drain_flags", flags, 32'h1);
      $display("txn drain: cnt=%0d flags=%h", pending_cnt, flags);

      pulse_reset();
      cyc();

      // reserve and writeback together at pending=2
      dec_reserve = 1'b1; cyc(); cyc(); idle();
      #2 chk("two_cnt", 32'(pending_cnt), 32'd2);
      dec_reserve = 1'b1; wb_valid = 1'b1; wb_mask = 7'b0001000; wb_flags = 32'h40;
      cyc(); idle();
      #2 chk("both_cnt", 32'(pending_cnt), 32'd2);
      chk("both_flags", flags, 32'h40);
      chk("both_err", 32'(wb_err), 32'd0);
      wb_valid = 1'b1; cyc(); cyc(); idle();
      #2 chk("empty_cnt", 32'(pending_cnt), 32'd0);

      // writeback with nothing pending
      wb_valid = 1'b1; wb_mask = 7'b0000010; wb_flags = 32'h4;
      cyc(); idle();
      #2 chk("under_cnt", 32'(pending_cnt), 32'd0);
      chk("under_err", 32'(wb_err), 32'd1);
      chk("under_flags", flags, 32'h44);
      $display("txn underflow: cnt=%0d err=%0d flags=%h", pending_cnt, wb_err, flags);

      // flush with a same-cycle DF writeback and reserve
      dec_reserve = 1'b1; cyc(); cyc(); cyc(); idle();
      #2 chk("three_cnt", 32'(pending_cnt), 32'd3);
      flush = 1'b1; dec_reserve = 1'b1; wb_valid = 1'b1;
      wb_mask = 7'b0100000; wb_flags = 32'h400;
      cyc(); idle();
      #2 chk("flush_cnt", 32'(pending_cnt), 32'd0);
      chk("flush_flags", flags, 32'h444);
      chk("flush_ready", 32'(flags_ready), 32'd1);
      cyc();
      chk("flush_cnt_hold", 32'(pending_cnt), 32'd0);
      $display("txn flush: cnt=%0d flags=%h", pending_cnt, flags);

      // asynchronous reset mid-cycle
      dec_reserve = 1'b1; cyc(); cyc(); idle();
      #2 chk("pre_rst_cnt", 32'(pending_cnt), 32'd2);
      CLR = 1'b0;
      #1;
      chk("arst_flags", flags, 32'h0);
      chk("arst_cnt", 32'(pending_cnt), 32'd0);
      chk("arst_err", 32'(wb_err), 32'd0);
      chk("arst_full", 32'(full), 32'd0);
      chk("arst_ready", 32'(flags_ready), 32'd1);
      CLR = 1'b1;
      $display("txn async reset: flags=%h cnt=%0d", flags, pending_cnt);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
